// File: rtl/fpu_normalize_seq.sv
// ---------------------------------------------------------------------------
// fpu_normalize_seq
//   Multi-cycle mantissa normalizer for the FPU8087 datapath. It scans the
//   mantissa one byte per cycle with an 8-bit leading-zero count and shifts
//   it left until the MSB is 1. The exponent is reduced by the total shift.
//   This costs a few cycles of latency in exchange for a much smaller
//   datapath than a full-width LZC plus a barrel shifter.
//
// Optional feature (compile-time macro FPU_NORM_DENORM_CLAMP_EN):
//   Gradual underflow. The total shift is limited to in_exp, so a result
//   that would underflow stays denormal, with out_exp = 0.
//
// Ports:
//   i_clk          system clock; all registers update on the rising edge
//   i_reset        synchronous, active-high reset
//   i_start        request pulse; sampled only in IDLE
//   i_in_mant      unnormalized mantissa (WIDTH bits)
//   i_in_exp       biased exponent (EXP_W bits)
//   o_busy         high from the cycle after an accepted start through done
//   o_done         one-cycle pulse; the results are valid from this cycle on
//   o_out_mant     normalized mantissa
//   o_out_exp      adjusted exponent (in_exp - shift_count, modulo 2^EXP_W)
//   o_shift_count  total left shift applied
//   o_zero         input mantissa was all zeros
//   o_underflow    total leading zeros exceeded in_exp
// ---------------------------------------------------------------------------
module fpu_normalize_seq #(
  parameter int WIDTH = 64,
  parameter int EXP_W = 15,
  parameter int SW    = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_in_mant,
  input  logic [EXP_W-1:0] i_in_exp,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_out_mant,
  output logic [EXP_W-1:0] o_out_exp,
  output logic [SW-1:0]    o_shift_count,
  output logic             o_zero,
  output logic             o_underflow
);

  // Compare width wide enough to hold both the shift count and the exponent.
  localparam int CW = ((SW > EXP_W) ? SW : EXP_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Leading zeros of one byte. An all-zero byte gives 8.
  function automatic logic [3:0] lzc8(input logic [7:0] b);
    logic [3:0] n;
    casez (b)
      8'b1???????: n = 4'd0;
      8'b01??????: n = 4'd1;
      8'b001?????: n = 4'd2;
      8'b0001????: n = 4'd3;
      8'b00001???: n = 4'd4;
      8'b000001??: n = 4'd5;
      8'b0000001?: n = 4'd6;
      8'b00000001: n = 4'd7;
      default:     n = 4'd8;
    endcase
    return n;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_mant;
  logic [EXP_W-1:0] r_exp;
  logic [SW-1:0]    r_acc;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out_mant;
  logic [EXP_W-1:0] r_out_exp;
  logic [SW-1:0]    r_shift_count;
  logic             r_zero;
  logic             r_underflow;

  logic [7:0]       w_top;
  logic             w_top_zero;
  logic [3:0]       w_step_amt;
  logic [3:0]       w_shift;
  logic [WIDTH-1:0] w_new_mant;
  logic [SW-1:0]    w_new_acc;
  logic [EXP_W-1:0] w_new_exp;
  logic             w_finish;
  logic             w_underflow;
`ifdef FPU_NORM_DENORM_CLAMP_EN
  logic [EXP_W-1:0] w_budget;
`endif

  // One SCAN step: work out the shift for the current top byte and the result it gives.
  always_comb begin
    w_top      = r_mant[WIDTH-1 -: 8];
    w_top_zero = (w_top == 8'd0);
    w_step_amt = w_top_zero ? 4'd8 : lzc8(w_top);
`ifdef FPU_NORM_DENORM_CLAMP_EN
    // The shift budget left is in_exp minus the shift already applied.
    // The accumulator never passes in_exp, so this never wraps.
    w_budget = r_exp - EXP_W'(r_acc);
    if (w_budget < EXP_W'(w_step_amt)) begin
      w_shift = w_budget[3:0];
    end else begin
      w_shift = w_step_amt;
    end
    w_new_mant = r_mant << w_shift;
    w_new_acc  = r_acc + SW'(w_shift);
    // Stop once a nonzero byte is reached or the budget is used up.
    w_finish   = !w_top_zero || (w_budget <= EXP_W'(w_step_amt));
    // If the budget ran out before the MSB reached the top, the result is denormal.
    w_underflow = ~w_new_mant[WIDTH-1];
`else
    w_shift     = w_step_amt;
    w_new_mant  = r_mant << w_shift;
    w_new_acc   = r_acc + SW'(w_shift);
    w_finish    = !w_top_zero;
    w_underflow = (CW'(w_new_acc) > CW'(r_exp));
`endif
    w_new_exp = r_exp - EXP_W'(w_new_acc);
  end

  // Control FSM, the scan datapath registers and the registered result outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_mant        <= {WIDTH{1'b0}};
      r_exp         <= {EXP_W{1'b0}};
      r_acc         <= {SW{1'b0}};
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_out_mant    <= {WIDTH{1'b0}};
      r_out_exp     <= {EXP_W{1'b0}};
      r_shift_count <= {SW{1'b0}};
      r_zero        <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_busy <= 1'b1;
            if (i_in_mant == {WIDTH{1'b0}}) begin
              // A zero mantissa skips the scan and goes straight to DONE.
              r_out_mant    <= {WIDTH{1'b0}};
              r_out_exp     <= {EXP_W{1'b0}};
              r_shift_count <= {SW{1'b0}};
              r_zero        <= 1'b1;
              r_underflow   <= 1'b0;
              r_done        <= 1'b1;
              r_state       <= ST_DONE;
            end else begin
              r_mant  <= i_in_mant;
              r_exp   <= i_in_exp;
              r_acc   <= {SW{1'b0}};
              r_state <= ST_SCAN;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_finish) begin
            r_out_mant    <= w_new_mant;
            r_out_exp     <= w_new_exp;
            r_shift_count <= w_new_acc;
            r_zero        <= 1'b0;
            r_underflow   <= w_underflow;
            r_done        <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_mant <= w_new_mant;
            r_acc  <= w_new_acc;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_out_mant    = r_out_mant;
  assign o_out_exp     = r_out_exp;
  assign o_shift_count = r_shift_count;
  assign o_zero        = r_zero;
  assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_fpu_normalize_seq.sv
module tb_fpu_normalize_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] in_mant;
  logic [14:0] in_exp;
  logic        busy;
  logic        done;
  logic [63:0] out_mant;
  logic [14:0] out_exp;
  logic [6:0]  shift_count;
  logic        zero;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] mant;
    logic [14:0] exp;
    logic [6:0]  sc;
    logic        zero;
    logic        ufl;
    int          lat;
  } res_t;

  res_t last;

  fpu_normalize_seq dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_in_mant     (in_mant),
    .i_in_exp      (in_exp),
    .o_busy        (busy),
    .o_done        (done),
    .o_out_mant    (out_mant),
    .o_out_exp     (out_exp),
    .o_shift_count (shift_count),
    .o_zero        (zero),
    .o_underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count the leading zeros of the whole word and derive the
  // result with plain arithmetic. Latency follows from the number of zero bytes.
  function automatic res_t model(input logic [63:0] m, input logic [14:0] e);
    res_t r;
    int lz;
    int sh;
    lz = 0;
    while (lz < 64 && m[63-lz] == 1'b0) lz++;
    if (lz == 64) begin
      r.mant = 64'd0; r.exp = 15'd0; r.sc = 7'd0; r.zero = 1'b1; r.ufl = 1'b0; r.lat = 1;
    end else begin
`ifdef FPU_NORM_DENORM_CLAMP_EN
      sh = (lz > int'(e)) ? int'(e) : lz;
`else
      sh = lz;
`endif
      r.mant = m << sh;
      r.exp  = 15'(int'(e) - sh);
      r.sc   = 7'(sh);
      r.zero = 1'b0;
      r.ufl  = (lz > int'(e));
      r.lat  = 2 + lz / 8;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at the next falling edge and check its result at the done pulse.
  task automatic run_op(input logic [63:0] m, input logic [14:0] e);
    res_t x;
    int cyc;
    int busy_low;
    x = model(m, e);
    last = x;
    @(negedge clk);
    start = 1'b1; in_mant = m; in_exp = e;
    @(negedge clk);
    start = 1'b0; in_mant = {$urandom, $urandom}; in_exp = 15'($urandom);
    cyc = 1; busy_low = 0;
    while (!done && cyc < 20) begin
      if (!busy) busy_low++;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
`ifdef FPU_NORM_DENORM_CLAMP_EN
    chk("latency_bound", 64'(cyc <= x.lat), 64'd1);
`else
    chk("latency", 64'(cyc), 64'(x.lat));
`endif
    chk("busy_at_done", 64'(busy), 64'd1);
    chk("busy_gap", 64'(busy_low), 64'd0);
    chk("out_mant", out_mant, x.mant);
    chk("out_exp", 64'(out_exp), 64'(x.exp));
    chk("shift_count", 64'(shift_count), 64'(x.sc));
    chk("zero", 64'(zero), 64'(x.zero));
    chk("underflow", 64'(underflow), 64'(x.ufl));
  endtask

  initial begin
    int ndone;
    int dcyc;
    logic [63:0] m;
    logic [14:0] e;
    int sh;

    reset = 1'b1; start = 1'b0; in_mant = 64'd0; in_exp = 15'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mant", out_mant, 64'd0);
    chk("rst_flags", {out_exp, shift_count, zero, underflow}, 64'd0);
    reset = 1'b0;

    // MSB already set.
    run_op(64'h8000_0000_0000_0000, 15'h3FFF);
    // Maximum shift, with explicit constants alongside the model.
    run_op(64'h0000_0000_0000_0001, 15'h3FFF);
    chk("max_sc_const", 64'(shift_count), 64'd63);
    chk("max_exp_const", 64'(out_exp), 64'h3FC0);
    // Zero input, back-to-back with the previous done.
    run_op(64'd0, 15'h1234);
    // Underflow.
    run_op(64'h0000_1000_0000_0000, 15'h0005);
`ifdef FPU_NORM_DENORM_CLAMP_EN
    chk("ufl_mant_const", out_mant, 64'h0002_0000_0000_0000);
`else
    chk("ufl_exp_const", 64'(out_exp), 64'h7FF2);
`endif

    // The outputs hold after done while idle.
    repeat (3) @(negedge clk);
    chk("hold_done", 64'(done), 64'd0);
    chk("hold_busy", 64'(busy), 64'd0);
    chk("hold_mant", out_mant, last.mant);
    chk("hold_exp", 64'(out_exp), 64'(last.exp));

    // A start while busy is ignored. The following start in cycle 10 is accepted.
    @(negedge clk);
    start = 1'b1; in_mant = 64'h1; in_exp = 15'h3FFF;
    ndone = 0; dcyc = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin start = 1'b1; in_mant = 64'h4000_0000_0000_0000; in_exp = 15'h0005; end
      if (c == 4) start = 1'b0;
      if (done) begin ndone++; dcyc = c; end
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_cycle", 64'(dcyc), 64'd9);
    chk("busy_start_sc", 64'(shift_count), 64'd63);
    chk("busy_start_mant", out_mant, 64'h8000_0000_0000_0000);
    run_op(64'h4000_0000_0000_0000, 15'h3FFF);
    chk("after_busy_sc", 64'(shift_count), 64'd1);

    // Reset in mid-operation, with a start raised in the same cycle as reset.
    @(negedge clk);
    start = 1'b1; in_mant = 64'h1; in_exp = 15'h3FFF;
    ndone = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 4) begin reset = 1'b1; start = 1'b1; in_mant = 64'h0100; end
      if (done) ndone++;
      if (c == 5) begin reset = 1'b0; start = 1'b0; end
    end
    chk("rst_mid_ndone", 64'(ndone), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_mant", out_mant, 64'd0);
    chk("rst_mid_flags", {out_exp, shift_count, zero, underflow}, 64'd0);
    run_op(64'h0000_0000_00F0_0000, 15'h0100);

    // Randomized operations spanning every leading-zero depth.
    for (int i = 0; i < 40; i++) begin
      m  = {$urandom, $urandom};
      sh = $urandom_range(0, 64);
      m  = (sh == 64) ? 64'd0 : (m >> sh);
      e  = ($urandom_range(0, 1) == 1) ? 15'($urandom) : 15'($urandom_range(0, 70));
      run_op(m, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_normalize_seq.md
Name: fpu_normalize_seq

Overview:
- Multi-cycle mantissa normalizer for the FPU8087 datapath.
- Scans a WIDTH-bit mantissa one byte per cycle using an internal 8-bit leading-zero count. Left-shifts the mantissa until its MSB is 1 and decrements the exponent by the total shift.
- Sits after the add/sub and multiply stages. Trades latency for area compared with a single-cycle 64-bit LZC plus barrel shifter.

Parameters:
- WIDTH, 64, mantissa width; must be a multiple of 8 and at least 16.
- EXP_W, 15, exponent width.
- SW, $clog2(WIDTH)+1, shift-count width (7 at default).

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- in_mant  in  WIDTH  unnormalized mantissa; captured on an accepted start.
- in_exp  in  EXP_W  biased exponent; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start up to and including the done cycle.
- done  out  1  single-cycle pulse; outputs are valid from this cycle on.
- out_mant  out  WIDTH  normalized mantissa.
- out_exp  out  EXP_W  adjusted exponent.
- shift_count  out  SW  total left shift applied.
- zero  out  1  input mantissa was all zeros.
- underflow  out  1  total leading zeros exceeded in_exp.

Behaviour:
- Reset values: every output and internal register is 0; state is IDLE. Reset in any state aborts the operation in progress. No done pulse is produced, and the result registers clear to 0 on the next edge.
- IDLE:
  - start=1 with in_mant==0 → go to DONE. Result: zero=1, out_mant=0, out_exp=0, shift_count=0, underflow=0.
  - start=1 with in_mant!=0 → capture in_mant and in_exp, clear the shift accumulator, go to SCAN.
  - start=0 → stay in IDLE.
- SCAN (one cycle per step):
  - Top byte == 0: shift the mantissa left by 8, add 8 to the accumulator, stay in SCAN.
  - Top byte != 0: compute l = leading zeros of the top byte (0..7), shift left by l, add l, go to DONE.
  - A nonzero mantissa always reaches a nonzero top byte within WIDTH/8 steps, so the shift never exceeds WIDTH-1.
- DONE: done=1 for exactly one cycle, then IDLE. The result registers are written on entry to DONE.
- Exponent and flags:
  - out_exp = in_exp − shift_count, computed modulo 2^EXP_W.
  - underflow = (shift_count > in_exp).
- Latency, counted from the edge that samples start (edge 0):
  - Zero input: done at cycle 1.
  - Otherwise: done at cycle 2+k, where k is the number of leading all-zero bytes. Maximum is 2+(WIDTH/8−1) = 9 at the default WIDTH.
- Holding and ignored inputs:
  - Outputs hold their last value after done until the next accepted start.
  - start is ignored while busy=1 or during DONE; it is not queued.
  - start asserted in the same cycle as reset is discarded.
- Back-to-back: a start in the cycle immediately after DONE (state back in IDLE) is accepted.

Optional Feature:
- Macro: FPU_NORM_DENORM_CLAMP_EN.
- When defined:
  - Gradual underflow: the total shift is limited to in_exp.
  - Each SCAN step shifts by min(step amount, in_exp − accumulated shift).
  - When the remaining budget reaches 0, the block goes to DONE with out_exp=0 and underflow=1; the mantissa is left denormal.
  - If the budget is exactly used up by a step that also normalizes, the result is out_exp=0 with underflow=0.
  - Latency can be shorter than 2+k but never longer.
- When not defined: full normalization with modulo exponent wrap, as described in Behaviour.

Test Plan:
- 1. MSB already set: start, in_mant=0x8000_0000_0000_0000, in_exp=0x3FFF → done at cycle 2; out_mant unchanged; shift_count=0; out_exp=0x3FFF; underflow=0.
- 2. Maximum shift: in_mant=0x0000_0000_0000_0001, in_exp=0x3FFF → done at cycle 9; out_mant=0x8000_0000_0000_0000; shift_count=63; out_exp=0x3FC0; busy high on cycles 1–9.
- 3. Zero input: in_mant=0, in_exp=0x1234 → done at cycle 1; zero=1; out_mant=0; out_exp=0; shift_count=0.
- 4. Underflow: in_mant=0x0000_1000_0000_0000, in_exp=0x0005.
  - Macro off: done at cycle 4; shift_count=19; out_mant=0x8000_0000_0000_0000; out_exp=0x7FF2; underflow=1.
  - Macro on: shift_count=5; out_mant=0x0002_0000_0000_0000; out_exp=0; underflow=1.
- 5. Start while busy: start case 2, then pulse start with in_mant=0x4000_0000_0000_0000 at cycle 3 → ignored; the case-2 result is produced unchanged with a single done pulse. A new start at cycle 10 is accepted and gives shift_count=1.
- 6. Reset mid-operation: start case 2, assert reset at cycle 4 for one cycle → no done pulse; all outputs 0 from cycle 5. A start at cycle 6 completes normally.
